// File: rtl/step_seek_ctrl.sv
// Host-side seek controller: generates STEP/DIR to move the floppy head to a
// requested track, or recalibrates to track 0 using the TR0 sensor.
module step_seek_ctrl #(
  parameter int unsigned PULSE_CYC  = 1000,
  parameter int unsigned RATE_CYC   = 60000,
  parameter int unsigned DIR_CYC    = 100,
  parameter int unsigned SETTLE_CYC = 300000,
  parameter int unsigned MAX_TRK    = 80,
  parameter int unsigned RECAL_MAX  = 85
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       seek_start,
  input  logic       recal,
  input  logic [6:0] target_trk,
  input  logic       tr0_n,
  output logic       step_n,
  output logic       dir,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [6:0] cur_trk,
  output logic       trk_valid
);

  localparam int unsigned RW = $clog2(RECAL_MAX + 1);

  typedef enum logic [2:0] {IDLE, DIRSET, PULSE, GAP, SETTLE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [6:0]    tgt_q, tgt_d;
  logic [6:0]    cur_trk_q, cur_trk_d;
  logic          is_recal_q, is_recal_d;
  logic          step_n_q, step_n_d;
  logic          dir_q, dir_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          trk_valid_q, trk_valid_d;
  logic          tr0_s1_q, tr0_s2_q;
  logic          tr0_act;
  logic          tmo;

  assign tr0_act = ~tr0_s2_q;
  assign tmo     = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = tmo ? '0 : cnt_q - 32'd1;
    rcnt_d      = rcnt_q;
    tgt_d       = tgt_q;
    cur_trk_d   = cur_trk_q;
    is_recal_d  = is_recal_q;
    step_n_d    = step_n_q;
    dir_d       = dir_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    trk_valid_d = trk_valid_q;

    case (state_q)
      IDLE: begin
        if (recal) begin
          is_recal_d = 1'b1;
          dir_d      = 1'b1;
          busy_d     = 1'b1;
          rcnt_d     = '0;
          state_d    = DIRSET;
          cnt_d      = 32'(DIR_CYC - 1);
        end else if (seek_start) begin
          if (!trk_valid_q || (32'(target_trk) >= MAX_TRK)) begin
            err_d = 1'b1;
          end else if (target_trk == cur_trk_q) begin
            done_d = 1'b1;
          end else begin
            is_recal_d = 1'b0;
            tgt_d      = target_trk;
            dir_d      = (target_trk < cur_trk_q);
            busy_d     = 1'b1;
            state_d    = DIRSET;
            cnt_d      = 32'(DIR_CYC - 1);
          end
        end
      end
      DIRSET: begin
        if (tmo) begin
          if (is_recal_q && tr0_act) begin
            state_d = SETTLE;
            cnt_d   = 32'(SETTLE_CYC - 1);
          end else begin
            state_d  = PULSE;
            step_n_d = 1'b0;
            cnt_d    = 32'(PULSE_CYC - 1);
          end
        end
      end
      PULSE: begin
        if (tmo) begin
          state_d  = GAP;
          step_n_d = 1'b1;
          cnt_d    = 32'(RATE_CYC - 1);
          // Position moves with the rising edge, which is when the drive steps.
          if (is_recal_q) rcnt_d = rcnt_q + RW'(1);
          else if (dir_q) cur_trk_d = cur_trk_q - 7'd1;
          else            cur_trk_d = cur_trk_q + 7'd1;
        end
      end
      GAP: begin
        if (tmo) begin
          if (is_recal_q ? tr0_act : (cur_trk_q == tgt_q)) begin
            state_d = SETTLE;
            cnt_d   = 32'(SETTLE_CYC - 1);
          end else if (is_recal_q && (rcnt_q == RW'(RECAL_MAX))) begin
            state_d     = IDLE;
            err_d       = 1'b1;
            busy_d      = 1'b0;
            trk_valid_d = 1'b0;
          end else begin
            state_d  = PULSE;
            step_n_d = 1'b0;
            cnt_d    = 32'(PULSE_CYC - 1);
          end
        end
      end
      SETTLE: begin
        if (tmo) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          if (is_recal_q) begin
            cur_trk_d   = '0;
            trk_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rcnt_q      <= '0;
      tgt_q       <= '0;
      cur_trk_q   <= '0;
      is_recal_q  <= 1'b0;
      step_n_q    <= 1'b1;
      dir_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      trk_valid_q <= 1'b0;
      tr0_s1_q    <= 1'b1;
      tr0_s2_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rcnt_q      <= rcnt_d;
      tgt_q       <= tgt_d;
      cur_trk_q   <= cur_trk_d;
      is_recal_q  <= is_recal_d;
      step_n_q    <= step_n_d;
      dir_q       <= dir_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      trk_valid_q <= trk_valid_d;
      tr0_s1_q    <= tr0_n;
      tr0_s2_q    <= tr0_s1_q;
    end
  end

  assign step_n    = step_n_q;
  assign dir       = dir_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cur_trk   = cur_trk_q;
  assign trk_valid = trk_valid_q;

endmodule

// File: tb/tb_step_seek_ctrl.sv
// Directed bench for step_seek_ctrl with a small drive model providing TR0.
module tb_step_seek_ctrl;

  localparam int unsigned PULSE_CYC  = 4;
  localparam int unsigned RATE_CYC   = 8;
  localparam int unsigned DIR_CYC    = 2;
  localparam int unsigned SETTLE_CYC = 10;
  localparam int unsigned MAX_TRK    = 80;
  localparam int unsigned RECAL_MAX  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       seek_start = 1'b0;
  logic       recal = 1'b0;
  logic [6:0] target_trk = '0;
  logic       tr0_n;
  logic       step_n, dir, busy, done, err, trk_valid;
  logic [6:0] cur_trk;

  int   n_run = 0;
  int   n_fail = 0;

  // Drive model: physical head position, stepping on rising step_n.
  int   pos = 3;
  logic tr0_stuck = 1'b0;
  assign tr0_n = tr0_stuck | (pos != 0);

  always #5 clk = ~clk;

  step_seek_ctrl #(
    .PULSE_CYC(PULSE_CYC), .RATE_CYC(RATE_CYC), .DIR_CYC(DIR_CYC),
    .SETTLE_CYC(SETTLE_CYC), .MAX_TRK(MAX_TRK), .RECAL_MAX(RECAL_MAX)
  ) dut (
    .clk(clk), .rst(rst), .seek_start(seek_start), .recal(recal),
    .target_trk(target_trk), .tr0_n(tr0_n), .step_n(step_n), .dir(dir),
    .busy(busy), .done(done), .err(err), .cur_trk(cur_trk), .trk_valid(trk_valid)
  );

  always @(posedge step_n) begin
    if (!rst) begin
      if (dir) pos = (pos > 0) ? pos - 1 : 0;
      else     pos = pos + 1;
    end
  end

  // Pulse-shape monitor: widths, pulse count, cur_trk at each rise, dir stability.
  int         lo_run = 0, hi_run = 0, pulses = 0;
  int         lo_bad = 0, hi_bad = 0, dir_bad = 0;
  logic       prev_busy = 1'b0, prev_dir = 1'b1;
  logic [6:0] rise_trk [64];

  always @(negedge clk) begin
    if (rst) begin
      lo_run = 0;
      hi_run = 0;
      prev_busy = 1'b0;
    end else begin
      if (!step_n) begin
        if (lo_run == 0 && hi_run != 0 && hi_run != RATE_CYC) hi_bad++;
        lo_run++;
        hi_run = 0;
      end else if (lo_run != 0) begin
        if (lo_run != PULSE_CYC) lo_bad++;
        if (pulses < 64) rise_trk[pulses] = cur_trk;
        pulses++;
        lo_run = 0;
        hi_run = 1;
      end else if (hi_run != 0) begin
        hi_run = busy ? hi_run + 1 : 0;
      end
      if (busy && prev_busy && dir != prev_dir) dir_bad++;
      prev_busy = busy;
      prev_dir  = dir;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cmd(input logic s, input logic r, input logic [6:0] t);
    @(negedge clk);
    seek_start = s;
    recal      = r;
    target_trk = t;
    @(posedge clk);
    #1;
    seek_start = 1'b0;
    recal      = 1'b0;
  endtask

  // Cycles from acceptance edge until done/err is seen; bounded.
  task automatic wait_evt(output int cyc, output logic d, output logic e,
                          output int busy_lo, output logic extra);
    cyc = 0; d = 1'b0; e = 1'b0; busy_lo = 0;
    while (cyc < 2000 && !d && !e) begin
      @(negedge clk);
      cyc++;
      d = done;
      e = err;
      if (!d && !e && !busy) busy_lo++;
    end
    @(negedge clk);
    extra = done | err;
  endtask

  int   c, bl, p0, k, b;
  logic d, e, x;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_step_n", step_n, 1);
    chk("rst_dir", dir, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cur_trk", cur_trk, 0);
    chk("rst_trk_valid", trk_valid, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Seek before any recal is rejected
    p0 = pulses;
    cmd(1'b1, 1'b0, 7'd5);
    wait_evt(c, d, e, bl, x);
    chk("noval_err", e, 1);
    chk("noval_done", d, 0);
    chk("noval_cyc", c, 1);
    chk("noval_busy", busy, 0);
    chk("noval_steps", pulses - p0, 0);

    // Recal from physical track 3
    p0 = pulses;
    cmd(1'b0, 1'b1, 7'd0);
    chk("recal_busy", busy, 1);
    chk("recal_dir", dir, 1);
    wait_evt(c, d, e, bl, x);
    chk("recal_done", d, 1);
    chk("recal_noerr", e, 0);
    chk("recal_cyc", c, 49);
    chk("recal_busylo", bl, 0);
    chk("recal_onepulse", x, 0);
    chk("recal_steps", pulses - p0, 3);
    chk("recal_trk", cur_trk, 0);
    chk("recal_valid", trk_valid, 1);
    chk("recal_busy_end", busy, 0);

    // Seek 0 -> 5
    p0 = pulses;
    cmd(1'b1, 1'b0, 7'd5);
    chk("s5_dir", dir, 0);
    chk("s5_busy", busy, 1);
    wait_evt(c, d, e, bl, x);
    chk("s5_done", d, 1);
    chk("s5_cyc", c, 73);
    chk("s5_busylo", bl, 0);
    chk("s5_onepulse", x, 0);
    chk("s5_steps", pulses - p0, 5);
    for (int i = 0; i < 5; i++) chk("s5_rise_trk", rise_trk[p0 + i], i + 1);
    chk("s5_trk", cur_trk, 5);

    // Seek 5 -> 2, then same track again
    p0 = pulses;
    cmd(1'b1, 1'b0, 7'd2);
    chk("s2_dir", dir, 1);
    wait_evt(c, d, e, bl, x);
    chk("s2_done", d, 1);
    chk("s2_cyc", c, 49);
    chk("s2_steps", pulses - p0, 3);
    for (int i = 0; i < 3; i++) chk("s2_rise_trk", rise_trk[p0 + i], 4 - i);
    chk("s2_trk", cur_trk, 2);
    p0 = pulses;
    cmd(1'b1, 1'b0, 7'd2);
    wait_evt(c, d, e, bl, x);
    chk("same_done", d, 1);
    chk("same_cyc", c, 1);
    chk("same_steps", pulses - p0, 0);
    chk("same_busy", busy, 0);

    // Out-of-range target
    p0 = pulses;
    cmd(1'b1, 1'b0, 7'd80);
    wait_evt(c, d, e, bl, x);
    chk("s80_err", e, 1);
    chk("s80_done", d, 0);
    chk("s80_cyc", c, 1);
    chk("s80_steps", pulses - p0, 0);
    chk("s80_trk", cur_trk, 2);

    // Recal with TR0 never asserting
    tr0_stuck = 1'b1;
    p0 = pulses;
    cmd(1'b0, 1'b1, 7'd0);
    wait_evt(c, d, e, bl, x);
    chk("rfail_err", e, 1);
    chk("rfail_done", d, 0);
    chk("rfail_cyc", c, 63);
    chk("rfail_steps", pulses - p0, 5);
    chk("rfail_valid", trk_valid, 0);
    chk("rfail_busy", busy, 0);

    // Recal already on track 0: no step
    tr0_stuck = 1'b0;
    repeat (4) @(negedge clk);
    p0 = pulses;
    cmd(1'b0, 1'b1, 7'd0);
    wait_evt(c, d, e, bl, x);
    chk("r0_done", d, 1);
    chk("r0_cyc", c, 13);
    chk("r0_steps", pulses - p0, 0);
    chk("r0_valid", trk_valid, 1);

    // Seek 0 -> 3 with a second seek_start while busy
    p0 = pulses;
    cmd(1'b1, 1'b0, 7'd3);
    repeat (4) @(negedge clk);
    cmd(1'b1, 1'b0, 7'd10);
    wait_evt(c, d, e, bl, x);
    chk("ign_done", d, 1);
    chk("ign_cyc", c, 44);
    chk("ign_onepulse", x, 0);
    chk("ign_steps", pulses - p0, 3);
    chk("ign_trk", cur_trk, 3);

    // recal and seek together: recal wins
    p0 = pulses;
    cmd(1'b1, 1'b1, 7'd7);
    chk("both_dir", dir, 1);
    wait_evt(c, d, e, bl, x);
    chk("both_done", d, 1);
    chk("both_cyc", c, 49);
    chk("both_steps", pulses - p0, 3);
    chk("both_trk", cur_trk, 0);
    b = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) b++;
    end
    chk("both_idle", b, 0);
    chk("lo_width", lo_bad, 0);
    chk("hi_width", hi_bad, 0);
    chk("dir_stable", dir_bad, 0);

    // Reset in the middle of a step pulse
    cmd(1'b1, 1'b0, 7'd4);
    k = 0;
    while (step_n && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("mid_low", step_n, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_step_n", step_n, 1);
    chk("mid_busy", busy, 0);
    chk("mid_dir", dir, 1);
    chk("mid_trk", cur_trk, 0);
    chk("mid_valid", trk_valid, 0);
    chk("mid_done", done, 0);
    chk("mid_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    cmd(1'b0, 1'b1, 7'd0);
    wait_evt(c, d, e, bl, x);
    chk("post_done", d, 1);
    chk("post_cyc", c, 13);
    chk("post_valid", trk_valid, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
